proc_dpath: RTL

Datapath end of the processor control-signal interface. It consumes per-cycle control bits (regA_en/sel, regB_en/sel, imm) from the controller and holds two architectural registers, A and B, with an adder. Every write to A pushes the new A value into a small output queue, which drains over a val/rdy stream to a sink (test harness or display). When the queue is full, the block asserts stall back to the controller and freezes.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/proc_dpath_if.sv | 28 ++
 rtl/proc_dpath_queue.sv | 51 +++++
 rtl/proc_dpath.sv | 74 +++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the processor control-signal interface between
// the controller and the datapath.
package proc_pkg;

  localparam logic SEL_IMM = 1'b0;
  localparam logic SEL_SUM = 1'b1;
  localparam logic SEL_A   = 1'b1;

  localparam int CW_REGA_EN  = 7;
  localparam int CW_REGA_SEL = 6;
  localparam int CW_REGB_EN  = 5;
  localparam int CW_REGB_SEL = 4;
  localparam int CW_IMM_MSB  = 3;
  localparam int CW_IMM_LSB  = 0;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic       regA_en;
    logic       regA_sel;
    logic       regB_en;
    logic       regB_sel;
    logic [3:0] imm;
  } ctrl_word_t;

endpackage

// File: rtl/proc_dpath_if.sv
// Control word plus output stream between controller/harness (master)
// and datapath (slave).
interface proc_dpath_if #(
  parameter int NBITS = 8
);
  logic             regA_en;
  logic             regA_sel;
  logic             regB_en;
  logic             regB_sel;
  logic [3:0]       imm;
  logic             stall;
  logic [NBITS-1:0] out_msg;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] regA_out;
  logic [NBITS-1:0] regB_out;
  logic             carry;

  modport master (
    output regA_en, regA_sel, regB_en, regB_sel, imm, out_rdy,
    input  stall, out_msg, out_val, regA_out, regB_out, carry
  );

  modport slave (
    input  regA_en, regA_sel, regB_en, regB_sel, imm, out_rdy,
    output stall, out_msg, out_val, regA_out, regB_out, carry
  );
endinterface

// File: rtl/proc_dpath_queue.sv
// Circular FIFO of DEPTH x NBITS entries; head reads as zero when empty.
module proc_dpath_queue #(
  parameter int NBITS = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_en,
  input  logic [NBITS-1:0] enq_data,
  input  logic             deq_en,
  output logic [NBITS-1:0] deq_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [NBITS-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic             enq_fire;
  logic             deq_fire;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign enq_fire = enq_en && !full;
  assign deq_fire = deq_en && !empty;
  assign deq_data = empty ? '0 : mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem[tail] <= enq_data;
  end

endmodule

// File: rtl/proc_dpath.sv
// Datapath with registers A/B, an adder and an output queue that
// records every A write; stalls the controller while the queue is full.
module proc_dpath #(
  parameter int NBITS = 8,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  proc_dpath_if.slave io
);
  import proc_pkg::*;

  logic [NBITS-1:0] a_q;
  logic [NBITS-1:0] b_q;
  logic             carry_q;
  logic [NBITS:0]   sum;
  logic [NBITS-1:0] imm_ext;
  logic [NBITS-1:0] a_next;
  logic [NBITS-1:0] b_next;
  logic             write_ok;
  logic             a_we;
  logic             b_we;
  logic             q_full;
  logic             q_empty;
  logic [NBITS-1:0] q_head;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign imm_ext  = NBITS'(io.imm);
  assign write_ok = !q_full;
  assign a_we     = io.regA_en && write_ok;
  assign b_we     = io.regB_en && write_ok;

  always_comb begin
    a_next = imm_ext;
    b_next = imm_ext;
    if (io.regA_sel == SEL_SUM) a_next = sum[NBITS-1:0];
    if (io.regB_sel == SEL_A)   b_next = a_q;
  end

  // Both writes use pre-edge A/B; carry stays set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      if (a_we) a_q <= a_next;
      if (b_we) b_q <= b_next;
      if (a_we && io.regA_sel == SEL_SUM && sum[NBITS]) carry_q <= 1'b1;
    end
  end

  proc_dpath_queue #(
    .NBITS (NBITS),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_en   (a_we),
    .enq_data (a_next),
    .deq_en   (io.out_rdy),
    .deq_data (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign io.stall    = q_full;
  assign io.out_val  = !q_empty;
  assign io.out_msg  = q_head;
  assign io.regA_out = a_q;
  assign io.regB_out = b_q;
  assign io.carry    = carry_q;

endmodule
